mm_store_buffer: RTL
====================

Name: mm_store_buffer

Overview:
- Store buffer downstream of the second memory-stage block.
- Captures cached store instructions leaving that stage as speculative entries; marks them committed when the store retires in WB; drops all speculative entries on an exception/ertn flush.
- Drains committed entries in order to the dcache write port.
- Flags load/store address conflicts so a younger load stalls.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, minimum 2.
- AW, 32, physical address width.
- DW, 32, data width; byte-strobe width is DW/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- push_i  in  1  allocate a speculative entry; driven by the memory stage as store_buffer_we & stage handshake
- push_paddr_i  in  AW  physical address; the word address is [AW-1:2]
- push_wdata_i  in  DW  store data, already byte-lane aligned
- push_wstrb_i  in  DW/8  byte strobes
- commit_i  in  1  WB retires the oldest speculative store
- cancel_i  in  1  exception flush; discard all speculative entries
- full_o  out  1  no free entry; upstream must not push
- empty_o  out  1  no valid entry
- wr_req_o  out  1  drain request to dcache
- wr_addr_o  out  AW  drain address
- wr_data_o  out  DW  drain data
- wr_strb_o  out  DW/8  drain strobes
- wr_ack_i  in  1  dcache accepted the drain in this cycle
- ld_addr_i  in  AW  physical address of the load in the memory stage
- ld_conflict_o  out  1  a valid entry matches ld_addr_i[AW-1:2]

Behaviour:
- Storage:
  - Circular array, one entry per slot: {addr, data, strb}.
  - Three pointers, each log2(DEPTH)+1 bits, with the MSB used as the wrap bit:
    - head: oldest entry, the next one to drain.
    - cmt: first speculative entry.
    - tail: next free slot.
  - Invariant: head <= cmt <= tail in circular order.
- Reset: head=cmt=tail=0, full_o=0, empty_o=1, wr_req_o=0, ld_conflict_o=0. wr_addr/data/strb_o read slot 0; their value is don't-care while wr_req_o=0.
- Status flags (from registered pointers only; no same-cycle bypass):
  - full_o = (tail-head)==DEPTH.
  - empty_o = tail==head.
- Push:
  - Writes slot tail[low bits]; tail increments on the next edge.
  - Push while full_o=1 is ignored, with no state change. A bench assertion flags it as an upstream protocol error.
- Commit:
  - cmt increments if cmt!=tail.
  - Commit with no speculative entry is ignored.
- Cancel:
  - tail <= cmt after any same-cycle commit has been applied, i.e. the new cmt.
  - A push in the same cycle is dropped.
  - Committed entries are never discarded.
- Drain:
  - wr_req_o = (head!=cmt); combinational from registers.
  - wr_addr/data/strb_o are driven from slot head.
  - Outputs stay stable while wr_req_o=1 and wr_ack_i=0.
  - wr_ack_i=1 with wr_req_o=1: head increments. wr_ack_i with wr_req_o=0 is ignored.
  - Zero-latency pop; at most one pop per cycle.
- Simultaneous events:
  - push + ack: both apply, so the count stays the same.
  - push + commit + ack: all three apply independently.
  - A pop freeing a slot does not clear full_o in the same cycle.
- ld_conflict_o:
  - Combinational OR over all slots in [head, tail) whose addr[AW-1:2] equals ld_addr_i[AW-1:2].
  - Strobes are ignored, so the check is conservative.
  - It covers both committed and speculative entries.
  - The entry being acked in the current cycle still counts.
- Uncached stores never enter this block.
- Reset asserted mid-operation: all pointers return to 0 on the next edge and pending entries are lost. wr_req_o drops in the cycle after reset is sampled.

Test Plan:
- Reset, then push addr 0x1000 data 0xAABBCCDD strb 0xF; no commit for 5 cycles -> wr_req_o=0 throughout, empty_o=0; ld_addr 0x1002 -> ld_conflict_o=1; ld_addr 0x1004 -> ld_conflict_o=0.
- Push 0x1000, commit next cycle, hold wr_ack_i=0 for 3 cycles then 1 -> wr_req_o=1 with addr 0x1000 stable for 4 cycles; empty_o=1 the cycle after the ack.
- DEPTH=4: push 4 stores (0x10/0x14/0x18/0x1C) -> full_o=1; 5th push ignored; commit 2, cancel -> tail=cmt, only 0x10 and 0x14 drain in order, then empty_o=1.
- Same cycle: commit_i, cancel_i, push_i with 2 speculative entries -> oldest committed, other speculative one and the pushed entry dropped; exactly one drain follows.
- Steady stream: push+commit every cycle with wr_ack_i=1 every cycle -> full_o never asserts, drains occur in push order with data matching, head wraps past DEPTH without corruption.
- Assert rst with 3 committed entries and wr_req_o=1 -> next cycle wr_req_o=0, empty_o=1, full_o=0; no further drains.

Source files
------------

// File: rtl/mm_store_buffer_if.sv
// Store-buffer bundle: pipeline push/commit/cancel, dcache drain, load-conflict probe.
// The master side is the surrounding pipeline and dcache; the slave side is the buffer.
interface mm_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              push_i;
  logic [AW-1:0]     push_paddr_i;
  logic [DW-1:0]     push_wdata_i;
  logic [DW/8-1:0]   push_wstrb_i;
  logic              commit_i;
  logic              cancel_i;
  logic              full_o;
  logic              empty_o;
  logic              wr_req_o;
  logic [AW-1:0]     wr_addr_o;
  logic [DW-1:0]     wr_data_o;
  logic [DW/8-1:0]   wr_strb_o;
  logic              wr_ack_i;
  logic [AW-1:0]     ld_addr_i;
  logic              ld_conflict_o;

  modport master (
    output push_i, push_paddr_i, push_wdata_i, push_wstrb_i,
    output commit_i, cancel_i, wr_ack_i, ld_addr_i,
    input  full_o, empty_o, wr_req_o, wr_addr_o, wr_data_o, wr_strb_o,
    input  ld_conflict_o
  );

  modport slave (
    input  push_i, push_paddr_i, push_wdata_i, push_wstrb_i,
    input  commit_i, cancel_i, wr_ack_i, ld_addr_i,
    output full_o, empty_o, wr_req_o, wr_addr_o, wr_data_o, wr_strb_o,
    output ld_conflict_o
  );
endinterface

// File: rtl/mm_store_buffer.sv
// Store buffer: speculative stores, committed at WB retire and drained in order to the dcache.
// Latency: push visible one edge later; drain is zero-latency from slot head.
// Backpressure: full_o stops upstream pushes; wr_ack_i low holds the drain stable.
module mm_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  mm_store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = DW / 8;

  typedef logic [PW:0] ptr_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mm_store_buffer: DEPTH must be a power of two and at least 2");
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  ptr_t head_q, cmt_q, tail_q;
  ptr_t head_d, cmt_d, tail_d;
  ptr_t count;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [SW-1:0] strb_q [DEPTH];

  logic full;
  logic empty;
  logic drain_req;
  logic push_ok;
  logic commit_ok;
  logic pop;

  logic [DEPTH-1:0] slot_vld;
  logic [DEPTH-1:0] slot_hit;

  assign count     = tail_q - head_q;
  assign full      = (count == ptr_t'(DEPTH));
  assign empty     = (tail_q == head_q);
  assign drain_req = (head_q != cmt_q);

  // A push racing a cancel belongs to the squashed path and is dropped.
  assign push_ok   = sb.push_i & ~full & ~sb.cancel_i;
  assign commit_ok = sb.commit_i & (cmt_q != tail_q);
  assign pop       = drain_req & sb.wr_ack_i;

  always_comb begin
    head_d = head_q;
    cmt_d  = cmt_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = head_q + ptr_t'(1);
    end
    if (commit_ok) begin
      cmt_d = cmt_q + ptr_t'(1);
    end
    // Cancel rolls tail back to the post-commit boundary, keeping committed work.
    if (sb.cancel_i) begin
      tail_d = cmt_d;
    end else if (push_ok) begin
      tail_d = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[tail_q[PW-1:0]] <= sb.push_paddr_i;
      data_q[tail_q[PW-1:0]] <= sb.push_wdata_i;
      strb_q[tail_q[PW-1:0]] <= sb.push_wstrb_i;
    end
  end

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PW-1:0] offs;
    assign offs        = PW'(g) - head_q[PW-1:0];
    assign slot_vld[g] = ({1'b0, offs} < count);
    assign slot_hit[g] = slot_vld[g] & (addr_q[g][AW-1:2] == sb.ld_addr_i[AW-1:2]);
  end

  assign sb.full_o        = full;
  assign sb.empty_o       = empty;
  assign sb.wr_req_o      = drain_req;
  assign sb.wr_addr_o     = addr_q[head_q[PW-1:0]];
  assign sb.wr_data_o     = data_q[head_q[PW-1:0]];
  assign sb.wr_strb_o     = strb_q[head_q[PW-1:0]];
  assign sb.ld_conflict_o = |slot_hit;

endmodule
